// File: rtl/call_request_unit.sv
// rtl/call_request_unit.sv - button debounce, request latching and one-shot call strobe issue
module call_request_unit #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int DWELL_CYCLES    = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_start,
    input  logic       btn_l1,
    input  logic       btn_l2,
    input  logic       btn_l3,
    input  logic [2:0] state,
    output logic       S,
    output logic       L1,
    output logic       L2,
    output logic       L3,
    output logic [3:0] pending,
    output logic       busy
);

    typedef enum logic {
        WAIT  = 1'b0,
        DWELL = 1'b1
    } fsm_t;

    localparam logic [7:0] DEB_LAST = 8'(DEBOUNCE_CYCLES - 1);
    localparam logic [7:0] DWELL_LD = 8'(DWELL_CYCLES);

    logic [3:0] raw;
    logic [3:0] sync1;
    logic [3:0] sync2;
    logic [3:0] deb;
    logic [3:0] deb_d;
    logic [7:0] dcnt [4];

    fsm_t       fsm;
    logic [7:0] dwell;
    logic       issue;
    logic [3:0] issue_mask;
    logic [3:0] set_mask;
    logic [3:0] clr_mask;

    assign raw = {btn_l3, btn_l2, btn_l1, btn_start};

    // Level flips on the edge the count would hit DEBOUNCE_CYCLES; any agreement restarts it.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1 <= '0;
            sync2 <= '0;
            deb   <= '0;
            deb_d <= '0;
            for (int i = 0; i < 4; i++) dcnt[i] <= '0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
            deb_d <= deb;
            for (int i = 0; i < 4; i++) begin
                if (sync2[i] == deb[i]) begin
                    dcnt[i] <= '0;
                end else if (dcnt[i] == DEB_LAST) begin
                    deb[i]  <= sync2[i];
                    dcnt[i] <= '0;
                end else begin
                    dcnt[i] <= dcnt[i] + 8'd1;
                end
            end
        end
    end

    always_comb begin
        issue      = (fsm == WAIT) && (state <= 3'd3) && pending[state[1:0]];
        issue_mask = issue ? (4'b0001 << state[1:0]) : 4'b0000;
        set_mask   = deb & ~deb_d;
        clr_mask   = (state == 3'd4) ? 4'b1111 : issue_mask;
    end

    // The counter reaches 0 one cycle before WAIT resumes, so busy drops a cycle early.
    always_ff @(posedge clk) begin
        if (rst) begin
            fsm     <= WAIT;
            dwell   <= '0;
            busy    <= 1'b0;
            pending <= '0;
            S       <= 1'b0;
            L1      <= 1'b0;
            L2      <= 1'b0;
            L3      <= 1'b0;
        end else begin
            pending          <= (pending | set_mask) & ~clr_mask;
            {L3, L2, L1, S}  <= issue_mask;
            case (fsm)
                WAIT: begin
                    if (issue) begin
                        fsm   <= DWELL;
                        dwell <= DWELL_LD;
                        busy  <= 1'b1;
                    end
                end
                DWELL: begin
                    if (dwell == 8'd0) begin
                        fsm <= WAIT;
                    end else begin
                        dwell <= dwell - 8'd1;
                        busy  <= (dwell != 8'd1);
                    end
                end
                default: fsm <= WAIT;
            endcase
        end
    end

endmodule

// File: tb/tb_call_request_unit.sv
// tb/tb_call_request_unit.sv - directed self-checking bench for call_request_unit
module tb_call_request_unit;

    logic       clk = 1'b0;
    logic       rst;
    logic       btn_start, btn_l1, btn_l2, btn_l3;
    logic [2:0] state;
    logic       S, L1, L2, L3;
    logic [3:0] pending;
    logic       busy;

    int total = 0;
    int bad   = 0;

    call_request_unit dut (
        .clk(clk), .rst(rst),
        .btn_start(btn_start), .btn_l1(btn_l1), .btn_l2(btn_l2), .btn_l3(btn_l3),
        .state(state),
        .S(S), .L1(L1), .L2(L2), .L3(L3),
        .pending(pending), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        total++;
        if (obs != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic int nstb();
        return int'(S) + int'(L1) + int'(L2) + int'(L3);
    endfunction

    initial begin
        int cnt, strobes, multi, t1, t2, t3;

        rst = 1'b1; state = 3'd0;
        btn_start = 1'b0; btn_l1 = 1'b0; btn_l2 = 1'b0; btn_l3 = 1'b0;
        step(); step();
        rst = 1'b0; btn_start = 1'b1;
        chk("reset_pending", pending, 0);
        chk("reset_busy", busy, 0);
        chk("reset_strobes", nstb(), 0);

        // start press latency and single strobe with dwell
        repeat (6) step();
        chk("start_not_yet", pending, 0);
        step();
        chk("start_pending_e7", pending, 1);
        step();
        chk("start_S_e8", S, 1);
        chk("start_cleared", pending, 0);
        chk("start_busy_e8", busy, 1);
        cnt = 1; strobes = 0;
        for (int i = 0; i < 12; i++) begin
            step();
            cnt += int'(busy);
            strobes += nstb();
        end
        chk("busy_cycles", cnt, 8);
        chk("one_strobe_only", strobes, 0);

        // short glitch filtered
        btn_start = 1'b0;
        repeat (10) step();
        btn_l1 = 1'b1;
        repeat (3) step();
        btn_l1 = 1'b0;
        strobes = 0;
        for (int i = 0; i < 15; i++) begin
            step();
            strobes += nstb();
        end
        chk("glitch_pending", pending, 0);
        chk("glitch_strobes", strobes, 0);

        // three floors served in order
        state = 3'd5;
        btn_l1 = 1'b1; btn_l2 = 1'b1; btn_l3 = 1'b1;
        repeat (10) step();
        btn_l1 = 1'b0; btn_l2 = 1'b0; btn_l3 = 1'b0;
        repeat (10) step();
        chk("floors_pending", pending, 4'b1110);
        state = 3'd1;
        t1 = -1; t2 = -1; t3 = -1; multi = 0;
        for (int c = 1; c <= 40; c++) begin
            step();
            if (nstb() > 1) multi++;
            if (S) multi++;
            if (L1) begin t1 = c; state = 3'd2; end
            if (L2) begin t2 = c; state = 3'd3; end
            if (L3) begin t3 = c; state = 3'd5; end
        end
        chk("L1_time", t1, 1);
        chk("L2_spacing", t2 - t1, 10);
        chk("L3_spacing", t3 - t2, 10);
        chk("strobe_overlap", multi, 0);
        chk("floors_drained", pending, 0);

        // trip complete clears, reserved state holds
        btn_l1 = 1'b1; btn_l3 = 1'b1;
        repeat (10) step();
        btn_l1 = 1'b0; btn_l3 = 1'b0;
        repeat (10) step();
        chk("pend_1010", pending, 4'b1010);
        state = 3'd4;
        step();
        chk("trip_clear", pending, 0);
        chk("trip_no_strobe", nstb(), 0);
        state = 3'd5;
        btn_l1 = 1'b1;
        repeat (10) step();
        btn_l1 = 1'b0;
        strobes = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            strobes += nstb();
        end
        chk("reserved_hold", pending, 4'b0010);
        chk("reserved_no_strobe", strobes, 0);

        // reset during dwell with l2 held
        btn_l2 = 1'b1; state = 3'd1;
        step();
        chk("pre_reset_L1", L1, 1);
        repeat (3) step();
        chk("pre_reset_busy", busy, 1);
        rst = 1'b1;
        step();
        chk("rst_outputs", {S, L1, L2, L3, busy}, 0);
        chk("rst_pending", pending, 0);
        rst = 1'b0; state = 3'd5;
        repeat (6) step();
        chk("post_rst_not_yet", pending, 0);
        step();
        chk("post_rst_l2", pending, 4'b0100);
        chk("post_rst_busy", busy, 0);

        // set and issue-clear on the same edge: clear wins
        btn_l2 = 1'b0;
        repeat (10) step();
        state = 3'd4;
        step();
        state = 3'd5;
        chk("pre_race_clear", pending, 0);
        btn_start = 1'b1;
        repeat (7) step();
        chk("race_first", pending, 1);
        btn_start = 1'b0;
        repeat (10) step();
        btn_start = 1'b1;
        repeat (6) step();
        chk("race_held", pending, 1);
        state = 3'd0;
        step();
        chk("race_S", S, 1);
        chk("race_clear_wins", pending, 0);
        btn_start = 1'b0;
        repeat (5) step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/call_request_unit.md
CALL_REQUEST_UNIT -- requirements
Module: call_request_unit

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 4, sets the consecutive stable cycles needed to accept a button level change; the legal range SHALL be 1..255.
REQ-002 Parameter DWELL_CYCLES, default 8, sets the cycles with strobes suppressed after each issued strobe; the legal range SHALL be 1..255.
REQ-003 clk  input  1  the single clock for the block; all flops SHALL be rising-edge triggered.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 btn_start, btn_l1, btn_l2, btn_l3  input  1 each  raw, asynchronous push-button levels; index 0..3 respectively.
REQ-006 state  input  3  current elevator state from the downstream state register (000 IDLE, 001 GROUND, 010 L1, 011 L2, 100 L3).
REQ-007 S, L1, L2, L3  output  1 each  registered single-cycle advance strobes feeding next-state logic.
REQ-008 pending  output  4  latched requests; bit 0 start, bits 1..3 floors 1..3.
REQ-009 busy  output  1  high while in DWELL.

Function
REQ-010 Each button SHALL pass through a 2-flop synchronizer before any other logic uses it.
REQ-011 Each synchronized button SHALL have its own debounce counter; the counter SHALL increment while the synced level differs from the debounced level and SHALL clear when they match.
REQ-012 The debounced level SHALL flip, and the counter clear, on the edge where the counter would reach DEBOUNCE_CYCLES.
REQ-013 A synced pulse shorter than DEBOUNCE_CYCLES cycles SHALL leave the debounced level unchanged.
REQ-014 A debounced 0->1 transition SHALL set the corresponding pending bit on the following edge; a 1->0 transition SHALL have no effect.
REQ-015 Latency: for a raw input high before edge 1 and held, the pending bit SHALL be visible after edge DEBOUNCE_CYCLES+3.
REQ-016 The controller FSM SHALL have two states, WAIT and DWELL; the reset state SHALL be WAIT.
REQ-017 WAIT, eligible bit per state: 000->pending[0]/S, 001->pending[1]/L1, 010->pending[2]/L2, 011->pending[3]/L3.
REQ-018 WAIT: if the eligible bit is set, the block SHALL on the next edge assert the matching strobe for exactly one cycle, clear that bit, load the dwell counter with DWELL_CYCLES, and enter DWELL.
REQ-019 WAIT with state 100 or 101..111: no strobe SHALL be issued and the FSM SHALL remain in WAIT.
REQ-020 DWELL: the dwell counter SHALL decrement each cycle, no strobe SHALL be issued, and on reaching 0 the FSM SHALL return to WAIT, re-evaluating the following cycle.
REQ-021 Strobe spacing SHALL therefore be at least DWELL_CYCLES+2 cycles, and busy SHALL be high for exactly DWELL_CYCLES cycles per strobe.
REQ-022 At most one of S/L1/L2/L3 SHALL be high in any cycle.
REQ-023 Whenever state==100 (trip complete), all pending bits SHALL clear on the next edge, regardless of FSM state.
REQ-024 When a set and a clear (issue or trip-complete) hit the same pending bit on the same edge, clear SHALL win.
REQ-025 Pending bits not eligible in the current state SHALL hold indefinitely; requests SHALL never be reordered or dropped except per REQ-023/024.
REQ-026 state values 101..111 SHALL not clear pending and SHALL not issue strobes.

Reset
REQ-027 When rst is high at an edge, all of the following SHALL clear: synchronizers, debounced levels, debounce counters, dwell counter, pending, strobes and busy; the FSM SHALL enter WAIT.
REQ-028 Reset asserted during DWELL or mid-debounce SHALL abort the activity with no strobe afterward until a fresh pending bit is set.
REQ-029 A button held through reset release SHALL be treated as a new press (debounced 0->1), setting pending per REQ-015.

Verification
REQ-030 Defaults, state=000, btn_start raised before edge 1 and held -> pending[0]=1 after edge 7; S=1 for one cycle after edge 8; pending[0]=0; busy=1 for 8 cycles.
REQ-031 btn_l1 high for 3 synced cycles, then low -> pending stays 0000 and no strobe.
REQ-032 pending=1110, state steps 001->010->011 immediately after each strobe -> L1, L2, L3 in order, rising edges 10 cycles apart, never two strobes high together.
REQ-033 state=100 with pending=1010 -> pending=0000 next cycle and no strobe; state=101 with pending=0010 -> pending held and no strobe.
REQ-034 rst asserted 3 cycles into DWELL with btn_l2 held -> strobes 0, busy 0, pending 0000; after release, pending[2]=1 at edge DEBOUNCE_CYCLES+3.
REQ-035 New btn_start debounced edge landing on the same edge S issues -> pending[0]=0 afterward (clear wins).
